fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-side control of an asynchronous (dual-clock) FIFO, in the read clock domain.
- Converts a level-style read request `rinc` into exactly one single-cycle read strobe per request.
- Maintains the binary read pointer and its Gray-coded copy for crossing to the write domain.
- Computes the registered empty flag by comparing against the write pointer, which is already Gray-coded and two-flop-synchronised into this domain.

Parameters:
- PTR_SZ, default 2: address width of the FIFO memory (depth = 2^PTR_SZ). Pointers are PTR_SZ+1 bits, with the extra MSB used for wrap detection.

Ports:
- clk  input  1  read-domain clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- rinc  input  1  read request level; one read is performed per assertion.
- rq2_waddr  input  PTR_SZ+1  synchronised Gray-coded write pointer.
- rempty  output  1  FIFO empty flag, registered.
- read_en  output  1  single-cycle memory read strobe.
- raddr  output  PTR_SZ  memory read address: low PTR_SZ bits of the binary read pointer.
- raddr_gray  output  PTR_SZ+1  Gray-coded read pointer, registered, sent to the write domain.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, binary pointer rbin=0, raddr_gray=0, rempty=1, read_en=0.
  - Reset applies mid-operation too: any READ or HOLD is abandoned and no pointer increment occurs.
- FSM, three states, Moore outputs:
  - IDLE: if rinc=1 and rempty=0, go to READ; otherwise stay. rinc while empty is ignored, not queued. If rinc is still high when rempty falls, the next edge goes to READ.
  - READ: lasts exactly one cycle. read_en=1; raddr shows the location being read. At the end of the cycle, rbin increments by 1. Next state is HOLD if rinc=1, else IDLE.
  - HOLD: wait for rinc=0, then go to IDLE. No reads occur while in HOLD, so holding rinc high yields exactly one read.
  - read_en=1 only in READ; 0 in IDLE and HOLD.
- Pointer arithmetic:
  - rbin_next = rbin + (state==READ), modulo 2^(PTR_SZ+1). Wrap-around is natural.
  - raddr = rbin[PTR_SZ-1:0], driven combinationally from the register.
  - raddr_gray <= (rbin_next >> 1) ^ rbin_next, registered on the same edge as rbin.
- Empty flag:
  - rempty <= (gray(rbin_next) == rq2_waddr), registered every cycle outside reset.
  - rempty rises on the same edge that the last available word's pointer increment lands.
  - rempty falls one clk edge after rq2_waddr changes to a value not equal to raddr_gray.
- Read latency: read_en is asserted starting the cycle after the edge that samples rinc=1 with rempty=0. The minimum request-to-request spacing for back-to-back reads is rinc low for at least one edge.
- rq2_waddr is assumed already synchronous to clk; no internal synchroniser.

Test Plan (PTR_SZ=2):
- Reset: hold rst=1 for 2 edges with rq2_waddr=2 (Gray of 3) -> rempty=1, read_en=0, raddr=0, raddr_gray=0. After rst falls, rempty=0 after 1 edge.
- Three reads: rq2_waddr=2, three rinc pulses (1 cycle high, 1 low) -> three read_en pulses with raddr=0,1,2. raddr_gray goes 1,3,2. rempty=1 on the edge after the third read.
- Empty blocking: with rempty=1, further rinc pulses -> read_en stays 0, raddr stays 3, raddr_gray=2.
- Wrap-around: from rbin=3, set rq2_waddr=0 -> rempty=0 next edge. Five rinc pulses -> reads at raddr=3,0,1,2,3. raddr_gray goes 6,7,5,4,0. rempty=1 after the fifth read (pointer back to 0 matches rq2_waddr=0).
- Held request: rinc held high for 6 cycles with FIFO non-empty -> exactly one read_en pulse. A second read occurs only after rinc drops and rises again.
- Reset mid-read: assert rst during the READ cycle -> no increment is applied. Next cycle rbin=0, raddr_gray=0, rempty=1, state IDLE.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: one read strobe per rinc
// request, binary/Gray read pointer and registered empty flag.
module fifo_rd_ctrl #(
   parameter int PTR_SZ = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rinc,
   input  logic [PTR_SZ:0]   rq2_waddr,
   output logic              rempty,
   output logic              read_en,
   output logic [PTR_SZ-1:0] raddr,
   output logic [PTR_SZ:0]   raddr_gray
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            r_state;
   logic [PTR_SZ:0]   r_rbin;
   logic [PTR_SZ:0]   r_rgray;
   logic              r_empty;
   logic              r_read_en;

   logic              w_inc;
   logic [PTR_SZ:0]   w_rbin_next;
   logic [PTR_SZ:0]   w_rgray_next;

   assign w_inc        = (r_state == READ);
   assign w_rbin_next  = r_rbin + {{PTR_SZ{1'b0}}, w_inc};
   assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

   assign rempty     = r_empty;
   assign read_en    = r_read_en;
   assign raddr      = r_rbin[PTR_SZ-1:0];
   assign raddr_gray = r_rgray;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rbin    <= '0;
         r_rgray   <= '0;
         r_empty   <= 1'b1;
         r_read_en <= 1'b0;
      end else begin
         r_rbin  <= w_rbin_next;
         r_rgray <= w_rgray_next;
         r_empty <= (w_rgray_next == rq2_waddr);
         // Requests seen while empty are dropped, not queued
         unique case (r_state)
            IDLE: begin
               if (rinc && !r_empty) begin
                  r_state   <= READ;
                  r_read_en <= 1'b1;
               end else begin
                  r_read_en <= 1'b0;
               end
            end
            READ: begin
               r_state   <= rinc ? HOLD : IDLE;
               r_read_en <= 1'b0;
            end
            HOLD: begin
               if (!rinc) r_state <= IDLE;
               r_read_en <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_read_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with PTR_SZ=2.
module tb_fifo_rd_ctrl;

   localparam int PTR_SZ = 2;

   logic              clk;
   logic              rst;
   logic              rinc;
   logic [PTR_SZ:0]   rq2_waddr;
   logic              rempty;
   logic              read_en;
   logic [PTR_SZ-1:0] raddr;
   logic [PTR_SZ:0]   raddr_gray;

   int n_vec;
   int n_err;

   fifo_rd_ctrl #(.PTR_SZ(PTR_SZ)) dut (
      .clk        (clk),
      .rst        (rst),
      .rinc       (rinc),
      .rq2_waddr  (rq2_waddr),
      .rempty     (rempty),
      .read_en    (read_en),
      .raddr      (raddr),
      .raddr_gray (raddr_gray)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      rinc      = 1'b0;
      rq2_waddr = 3'd2;
      step();
      step();
      n_vec++;
      if (rempty !== 1'b1 || read_en !== 1'b0 || raddr !== 2'd0 || raddr_gray !== 3'd0) begin
         n_err++;
         $display("FAIL reset: rempty=%b read_en=%b raddr=%0d gray=%0d, want 1 0 0 0",
                  rempty, read_en, raddr, raddr_gray);
      end
      rst = 1'b0;
      step();
      n_vec++;
      if (rempty !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_rempty: got %b want 0", rempty);
      end
   endtask

   task automatic test_three_reads();
      logic [1:0] exp_addr [3] = '{2'd0, 2'd1, 2'd2};
      logic [2:0] exp_gray [3] = '{3'd1, 3'd3, 3'd2};
      for (int i = 0; i < 3; i++) begin
         rinc = 1'b1;
         step();
         n_vec++;
         if (read_en !== 1'b1 || raddr !== exp_addr[i]) begin
            n_err++;
            $display("FAIL three_reads_strobe[%0d]: read_en=%b raddr=%0d want 1 %0d",
                     i, read_en, raddr, exp_addr[i]);
         end
         rinc = 1'b0;
         step();
         n_vec++;
         if (read_en !== 1'b0 || raddr_gray !== exp_gray[i]) begin
            n_err++;
            $display("FAIL three_reads_gray[%0d]: read_en=%b gray=%0d want 0 %0d",
                     i, read_en, raddr_gray, exp_gray[i]);
         end
      end
      n_vec++;
      if (rempty !== 1'b1) begin
         n_err++;
         $display("FAIL three_reads_empty: rempty=%b want 1", rempty);
      end
   endtask

   task automatic test_empty_block();
      for (int i = 0; i < 2; i++) begin
         rinc = 1'b1;
         step();
         n_vec++;
         if (read_en !== 1'b0) begin
            n_err++;
            $display("FAIL empty_block_strobe[%0d]: read_en=%b want 0", i, read_en);
         end
         rinc = 1'b0;
         step();
      end
      n_vec++;
      if (raddr !== 2'd3 || raddr_gray !== 3'd2 || rempty !== 1'b1) begin
         n_err++;
         $display("FAIL empty_block_state: raddr=%0d gray=%0d rempty=%b want 3 2 1",
                  raddr, raddr_gray, rempty);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp_addr [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      logic [2:0] exp_gray [5] = '{3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
      rq2_waddr = 3'd0;
      step();
      n_vec++;
      if (rempty !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_not_empty: rempty=%b want 0", rempty);
      end
      for (int i = 0; i < 5; i++) begin
         rinc = 1'b1;
         step();
         n_vec++;
         if (read_en !== 1'b1 || raddr !== exp_addr[i]) begin
            n_err++;
            $display("FAIL wrap_strobe[%0d]: read_en=%b raddr=%0d want 1 %0d",
                     i, read_en, raddr, exp_addr[i]);
         end
         rinc = 1'b0;
         step();
         n_vec++;
         if (raddr_gray !== exp_gray[i] || rempty !== (i == 4)) begin
            n_err++;
            $display("FAIL wrap_gray[%0d]: gray=%0d rempty=%b want %0d %b",
                     i, raddr_gray, rempty, exp_gray[i], (i == 4));
         end
      end
   endtask

   task automatic test_held_request();
      int pulses;
      pulses    = 0;
      rq2_waddr = 3'd3;
      step();
      rinc = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (read_en === 1'b1) pulses++;
      end
      n_vec++;
      if (pulses != 1) begin
         n_err++;
         $display("FAIL held_pulses: got %0d want 1", pulses);
      end
      n_vec++;
      if (raddr !== 2'd1 || raddr_gray !== 3'd1) begin
         n_err++;
         $display("FAIL held_ptr: raddr=%0d gray=%0d want 1 1", raddr, raddr_gray);
      end
      rinc = 1'b0;
      step();
      n_vec++;
      if (read_en !== 1'b0) begin
         n_err++;
         $display("FAIL held_release: read_en=%b want 0", read_en);
      end
      rinc = 1'b1;
      step();
      n_vec++;
      if (read_en !== 1'b1 || raddr !== 2'd1) begin
         n_err++;
         $display("FAIL held_second_read: read_en=%b raddr=%0d want 1 1", read_en, raddr);
      end
   endtask

   task automatic test_reset_mid_read();
      rinc = 1'b0;
      rst  = 1'b1;
      step();
      n_vec++;
      if (raddr !== 2'd0 || raddr_gray !== 3'd0 || rempty !== 1'b1 || read_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_read: raddr=%0d gray=%0d rempty=%b read_en=%b want 0 0 1 0",
                  raddr, raddr_gray, rempty, read_en);
      end
      rst = 1'b0;
      step();
      rinc = 1'b1;
      step();
      n_vec++;
      if (read_en !== 1'b1 || raddr !== 2'd0) begin
         n_err++;
         $display("FAIL post_reset_idle_read: read_en=%b raddr=%0d want 1 0", read_en, raddr);
      end
      rinc = 1'b0;
      step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_three_reads();
      test_empty_block();
      test_wrap();
      test_held_request();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
